lock_sequencer: RTL

- Supervisory controller for the switch-code verifier FSM.
- Owns the verifier's reset (vrst_n) and watches its 4-bit status code.
- Sequences attempts: unlock window on success, clear-and-rearm on failure, timed lockout after repeated failures.
- Optional entry timeout aborts stalled partial entries.
- Sits between the switch bank and the verifier; feeds the LED/status display.

---
 rtl/lock_sequencer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/lock_sequencer.sv
// lock_sequencer: supervisory controller for the switch-code verifier.
// It owns the verifier reset (vrst_n), watches the verifier status code and
// sequences attempts: an unlock window on success, clear-and-rearm on failure,
// and a timed lockout after MAX_FAIL consecutive failures.
// Optional build macro: ENTRY_TIMEOUT_EN adds an idle timer that aborts a
// stalled partial entry and counts it as a failure.
module lock_sequencer #(
  parameter int unsigned MAX_FAIL     = 3,
  parameter int unsigned UNLOCK_CYC   = 1000,
  parameter int unsigned LOCK_CYC     = 2000,
  parameter int unsigned ENTRY_TO_CYC = 500,
  parameter int unsigned MIN_CLR      = 2,
  localparam int unsigned FAIL_W      = $clog2(MAX_FAIL + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        status_in,
  input  logic              sw_any,
  output logic              vrst_n,
  output logic              unlock,
  output logic              locked,
  output logic [FAIL_W-1:0] fail_cnt,
  output logic [1:0]        state_out
);

  localparam int unsigned T_UL      = (UNLOCK_CYC > LOCK_CYC) ? UNLOCK_CYC : LOCK_CYC;
  localparam int unsigned T_ULE     = (T_UL > ENTRY_TO_CYC) ? T_UL : ENTRY_TO_CYC;
  localparam int unsigned TIMER_MAX = (T_ULE > MIN_CLR) ? T_ULE : MIN_CLR;
  localparam int unsigned TIMER_W   = $clog2(TIMER_MAX + 1);

  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_DONE = 4'd4;
  localparam logic [3:0] ST_ERR  = 4'd5;

  typedef enum logic [1:0] {
    S_CLEAR    = 2'd0,
    S_ARMED    = 2'd1,
    S_UNLOCKED = 2'd2,
    S_LOCKOUT  = 2'd3
  } state_t;

  state_t              r_state;
  logic [TIMER_W-1:0]  r_timer;
  logic [FAIL_W-1:0]   r_fail_cnt;
  logic                r_vrst_n;
  logic                r_unlock;
  logic                r_locked;

  state_t              w_state_nxt;
  logic [TIMER_W-1:0]  w_timer_nxt;
  logic [FAIL_W-1:0]   w_fail_nxt;
  logic [FAIL_W-1:0]   w_fail_inc;
  logic                w_fail_event;

`ifdef ENTRY_TIMEOUT_EN
  logic [3:0]          r_prev_status;

  // Previous status sample, used to detect activity during a partial entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev_status <= 4'd0;
    end else begin
      r_prev_status <= status_in;
    end
  end
`endif

  // Saturating increment of the consecutive-failure count
  assign w_fail_inc = (r_fail_cnt >= FAIL_W'(MAX_FAIL)) ? r_fail_cnt
                                                         : r_fail_cnt + FAIL_W'(1);

  // Next-state, shared timer and failure-count logic
  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = (r_timer != '0) ? r_timer - TIMER_W'(1) : r_timer;
    w_fail_nxt   = r_fail_cnt;
    w_fail_event = 1'b0;

    case (r_state)
      S_CLEAR: begin
        // Never arm the verifier while any switch is still raised
        if ((r_timer == '0) && !sw_any) begin
          w_state_nxt = S_ARMED;
`ifdef ENTRY_TIMEOUT_EN
          w_timer_nxt = TIMER_W'(ENTRY_TO_CYC - 1);
`else
          w_timer_nxt = '0;
`endif
        end
      end

      S_ARMED: begin
        w_timer_nxt = r_timer;
        if (status_in == ST_DONE) begin
          w_state_nxt = S_UNLOCKED;
          w_fail_nxt  = '0;
          w_timer_nxt = TIMER_W'(UNLOCK_CYC - 1);
        end else if (status_in >= ST_ERR) begin
          w_fail_event = 1'b1;
        end else begin
`ifdef ENTRY_TIMEOUT_EN
          if ((status_in == ST_IDLE) || (status_in != r_prev_status)) begin
            w_timer_nxt = TIMER_W'(ENTRY_TO_CYC - 1);
          end else if (r_timer == '0) begin
            w_fail_event = 1'b1;
          end else begin
            w_timer_nxt = r_timer - TIMER_W'(1);
          end
`endif
        end

        if (w_fail_event) begin
          w_fail_nxt = w_fail_inc;
          if (w_fail_inc == FAIL_W'(MAX_FAIL)) begin
            w_state_nxt = S_LOCKOUT;
            w_timer_nxt = TIMER_W'(LOCK_CYC - 1);
          end else begin
            w_state_nxt = S_CLEAR;
            w_timer_nxt = TIMER_W'(MIN_CLR - 1);
          end
        end
      end

      S_UNLOCKED: begin
        if (r_timer == '0) begin
          w_state_nxt = S_CLEAR;
          w_timer_nxt = TIMER_W'(MIN_CLR - 1);
        end
      end

      S_LOCKOUT: begin
        if (r_timer == '0) begin
          w_state_nxt = S_CLEAR;
          w_timer_nxt = TIMER_W'(MIN_CLR - 1);
          w_fail_nxt  = '0;
        end
      end

      default: begin
        w_state_nxt = S_CLEAR;
        w_timer_nxt = TIMER_W'(MIN_CLR - 1);
      end
    endcase
  end

  // State register; outputs are decoded from the next state so they change on the entry edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_CLEAR;
      r_timer    <= '0;
      r_fail_cnt <= '0;
      r_vrst_n   <= 1'b0;
      r_unlock   <= 1'b0;
      r_locked   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_timer    <= w_timer_nxt;
      r_fail_cnt <= w_fail_nxt;
      r_vrst_n   <= (w_state_nxt == S_ARMED) || (w_state_nxt == S_UNLOCKED);
      r_unlock   <= (w_state_nxt == S_UNLOCKED);
      r_locked   <= (w_state_nxt == S_LOCKOUT);
    end
  end

  assign vrst_n    = r_vrst_n;
  assign unlock    = r_unlock;
  assign locked    = r_locked;
  assign fail_cnt  = r_fail_cnt;
  assign state_out = r_state;

endmodule
